// File: rtl/download_pkg.sv
// Shared encodings for the ring download (flit reassembly) path.
// Optional error detection is enabled with DOWNLOAD_ERR_CHK_EN.
package download_pkg;

  localparam int MAX_FLITS = 11;
  localparam int FLIT_W    = 16;
  localparam int CNT_W     = 4;
  localparam int DATA_W    = (MAX_FLITS - 3) * FLIT_W;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RDY  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CTRL_SINGLE = 2'b00,
    CTRL_HEAD   = 2'b01,
    CTRL_BODY   = 2'b10,
    CTRL_TAIL   = 2'b11
  } ctrl_e;

endpackage

// File: rtl/download_fsm_datapath_if.sv
// Flit-in / message-out bundle of the download block.
// slave = the block itself, master = ring + cache controller side.
interface download_fsm_datapath_if;
  import download_pkg::*;

  logic                v_flit_in;
  flit_t               flit_in;
  logic [1:0]          ctrl_in;
  logic                flit_rdy_out;
  logic                v_msg_out;
  logic                msg_ack_in;
  flit_t               head_flit_out;
  flit_t               addrhi_out;
  flit_t               addrlo_out;
  logic [DATA_W-1:0]   data_out;
  logic [CNT_W-1:0]    flit_cnt_out;
  logic [1:0]          fsm_state_out;
  logic                err_out;

  modport master (
    output v_flit_in, flit_in, ctrl_in, msg_ack_in,
    input  flit_rdy_out, v_msg_out, head_flit_out,
    input  addrhi_out, addrlo_out, data_out,
    input  flit_cnt_out, fsm_state_out, err_out
  );

  modport slave (
    input  v_flit_in, flit_in, ctrl_in, msg_ack_in,
    output flit_rdy_out, v_msg_out, head_flit_out,
    output addrhi_out, addrlo_out, data_out,
    output flit_cnt_out, fsm_state_out, err_out
  );

endinterface

// File: rtl/download_datapath.sv
// Flit register file plus saturating slot counter.
// head_ld restarts the message, body_st appends at slot cnt.
module download_datapath #(
  parameter int MAX_FLITS = 11,
  parameter int FLIT_W    = 16,
  parameter int CNT_W     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              head_ld,
  input  logic                              body_st,
  input  logic [FLIT_W-1:0]                 flit_in,
  output logic [MAX_FLITS-1:0][FLIT_W-1:0]  flits,
  output logic [CNT_W-1:0]                  cnt,
  output logic                              eq_max
);

  logic                 body_we;
  logic [MAX_FLITS-1:0] slot_we;

  assign eq_max  = (cnt == CNT_W'(MAX_FLITS));
  assign body_we = body_st && !eq_max;

  always_comb begin
    slot_we = '0;
    for (int i = 0; i < MAX_FLITS; i++)
      slot_we[i] = body_we && (cnt == CNT_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        head_ld: cnt <= CNT_W'(1);
        body_we: cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // A new head clears the older slots so short messages read back zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flits <= '0;
    end else begin
      for (int i = 0; i < MAX_FLITS; i++) begin
        if (head_ld)
          flits[i] <= (i == 0) ? flit_in : '0;
        else if (slot_we[i])
          flits[i] <= flit_in;
      end
    end
  end

endmodule

// File: rtl/download_fsm_datapath.sv
// Receive-side flit reassembly: FSM + register datapath, one message held.
// Define DOWNLOAD_ERR_CHK_EN to enable the sticky protocol error flag.
module download_fsm_datapath #(
  parameter int MAX_FLITS = 11,
  parameter int FLIT_W    = 16
) (
  input logic                    clk,
  input logic                    rst,
  download_fsm_datapath_if.slave bus
);
  import download_pkg::*;

  state_e state_q;
  state_e state_d;
  ctrl_e  ctrl;

  logic is_busy;
  logic is_rdy;
  logic accept;
  logic is_head;
  logic head_ld;
  logic body_st;
  logic eq_max;

  logic [MAX_FLITS-1:0][FLIT_W-1:0] flits;
  logic [CNT_W-1:0]                 cnt;

  assign ctrl    = ctrl_e'(bus.ctrl_in);
  assign is_busy = (state_q == ST_BUSY);
  assign is_rdy  = (state_q == ST_RDY);
  assign accept  = bus.v_flit_in && !is_rdy;
  assign is_head = (ctrl == CTRL_HEAD) || (ctrl == CTRL_SINGLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The unused 2'b11 encoding falls into the IDLE branch.
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      is_rdy:
        state_d = bus.msg_ack_in ? ST_IDLE : ST_RDY;
      accept && is_head:
        state_d = (ctrl == CTRL_SINGLE) ? ST_RDY : ST_BUSY;
      accept && is_busy && (ctrl == CTRL_TAIL):
        state_d = ST_RDY;
      is_busy:
        state_d = ST_BUSY;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.flit_rdy_out  = !is_rdy;
    bus.v_msg_out     = is_rdy;
    bus.fsm_state_out = state_q;
    head_ld           = accept && is_head;
    body_st           = accept && is_busy && !is_head && !eq_max;
  end

  download_datapath #(
    .MAX_FLITS (MAX_FLITS),
    .FLIT_W    (FLIT_W),
    .CNT_W     (CNT_W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .head_ld (head_ld),
    .body_st (body_st),
    .flit_in (bus.flit_in),
    .flits   (flits),
    .cnt     (cnt),
    .eq_max  (eq_max)
  );

  assign bus.head_flit_out = flits[0];
  assign bus.addrhi_out    = flits[1];
  assign bus.addrlo_out    = flits[2];
  assign bus.flit_cnt_out  = cnt;

  // Flit 3 lands in the top lane of data_out.
  always_comb begin
    bus.data_out = '0;
    for (int i = 3; i < MAX_FLITS; i++)
      bus.data_out[(MAX_FLITS-1-i)*FLIT_W +: FLIT_W] = flits[i];
  end

`ifdef DOWNLOAD_ERR_CHK_EN
  logic err_ev;
  logic err_q;

  assign err_ev = accept &&
    (is_head ? is_busy : (!is_busy || eq_max));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_ev;
  end

  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif

endmodule

// File: tb/tb_download_fsm_datapath.sv
// Randomized + directed bench for download_fsm_datapath.
// Behavioural message model compared every cycle on the falling edge.
module tb_download_fsm_datapath;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  download_fsm_datapath_if bus();

  download_fsm_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: 0 = waiting for head, 1 = assembling, 2 = message held
  int          mode;
  int          n;
  logic [15:0] words [11];
  bit          merr;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0;
    n    = 0;
    merr = 1'b0;
    foreach (words[i]) words[i] = '0;
  endtask

  task automatic model_step();
    if (mode == 2) begin
      if (bus.msg_ack_in) mode = 0;
    end else if (bus.v_flit_in) begin
      if (bus.ctrl_in == 2'b00 || bus.ctrl_in == 2'b01) begin
        if (mode == 1) merr = 1'b1;
        foreach (words[i]) words[i] = '0;
        words[0] = bus.flit_in;
        n        = 1;
        mode     = (bus.ctrl_in == 2'b00) ? 2 : 1;
      end else if (mode == 1) begin
        if (n < 11) begin
          words[n] = bus.flit_in;
          n++;
        end else begin
          merr = 1'b1;
        end
        if (bus.ctrl_in == 2'b11) mode = 2;
      end else begin
        merr = 1'b1;
      end
    end
  endtask

  function automatic logic [127:0] exp_data();
    logic [127:0] d = '0;
    for (int k = 0; k < 8; k++) d = {d[111:0], words[3+k]};
    return d;
  endfunction

  function automatic bit exp_err();
`ifdef DOWNLOAD_ERR_CHK_EN
    return merr;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", bus.fsm_state_out, 128'(mode));
      chk("rdy",   bus.flit_rdy_out, 128'(mode != 2));
      chk("vmsg",  bus.v_msg_out, 128'(mode == 2));
      chk("cnt",   bus.flit_cnt_out, 128'(n));
      chk("head",  bus.head_flit_out, words[0]);
      chk("ahi",   bus.addrhi_out, words[1]);
      chk("alo",   bus.addrlo_out, words[2]);
      chk("data",  bus.data_out, exp_data());
      chk("err",   bus.err_out, exp_err());
    end
  end

  task automatic step(input bit v, input logic [1:0] c,
                      input logic [15:0] f, input bit ack);
    #2;
    bus.v_flit_in  = v;
    bus.ctrl_in    = c;
    bus.flit_in    = f;
    bus.msg_ack_in = ack;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    bus.v_flit_in  = 1'b0;
    bus.msg_ack_in = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_cnt",   bus.flit_cnt_out, 0);
    chk("rst_state", bus.fsm_state_out, 0);
    chk("rst_rdy",   bus.flit_rdy_out, 1);
    chk("rst_head",  bus.head_flit_out, 0);
    chk("rst_err",   bus.err_out, 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  bit lit_err;

  initial begin
`ifdef DOWNLOAD_ERR_CHK_EN
    lit_err = 1'b1;
`else
    lit_err = 1'b0;
`endif
    bus.v_flit_in  = 1'b0;
    bus.ctrl_in    = 2'b00;
    bus.flit_in    = '0;
    bus.msg_ack_in = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_rdy",  bus.flit_rdy_out, 1);
    chk("init_vmsg", bus.v_msg_out, 0);
    #2 rst = 1'b0;

    // 3-flit message
    step(1, 2'b01, 16'h1234, 0);
    step(1, 2'b10, 16'hA0A0, 0);
    step(1, 2'b11, 16'h0B0B, 0);
    chk("m3_vmsg", bus.v_msg_out, 1);
    chk("m3_rdy",  bus.flit_rdy_out, 0);
    chk("m3_head", bus.head_flit_out, 16'h1234);
    chk("m3_ahi",  bus.addrhi_out, 16'hA0A0);
    chk("m3_alo",  bus.addrlo_out, 16'h0B0B);
    chk("m3_data", bus.data_out, 0);
    chk("m3_cnt",  bus.flit_cnt_out, 3);
    step(0, 2'b00, 16'h0, 1);
    chk("m3_idle", bus.fsm_state_out, 0);

    // full 11-flit message, then held without ack
    step(1, 2'b01, 16'h1111, 0);
    step(1, 2'b10, 16'h2222, 0);
    step(1, 2'b10, 16'h3333, 0);
    for (int k = 1; k <= 7; k++) step(1, 2'b10, 16'hD000 + 16'(k), 0);
    step(1, 2'b11, 16'hD008, 0);
    chk("m11_dhi", bus.data_out[127:112], 16'hD001);
    chk("m11_dlo", bus.data_out[15:0], 16'hD008);
    chk("m11_cnt", bus.flit_cnt_out, 11);
    for (int k = 0; k < 5; k++) step(1, 2'b01, 16'(16'hE000 + k), 0);
    chk("hold_dlo",  bus.data_out[15:0], 16'hD008);
    chk("hold_head", bus.head_flit_out, 16'h1111);
    chk("hold_rdy",  bus.flit_rdy_out, 0);
    step(0, 2'b00, 16'h0, 1);

    // single-flit message, then head right after ack
    step(1, 2'b00, 16'h00FF, 0);
    chk("s_vmsg", bus.v_msg_out, 1);
    chk("s_cnt",  bus.flit_cnt_out, 1);
    step(0, 2'b00, 16'h0, 1);
    chk("s_idle", bus.fsm_state_out, 0);
    step(1, 2'b01, 16'h4242, 0);
    chk("s_busy", bus.fsm_state_out, 1);
    chk("s_head", bus.head_flit_out, 16'h4242);

    // restart by a new head mid-message
    step(1, 2'b10, 16'h7777, 0);
    step(1, 2'b01, 16'h5555, 0);
    chk("rs_cnt",  bus.flit_cnt_out, 1);
    chk("rs_head", bus.head_flit_out, 16'h5555);
    chk("rs_ahi",  bus.addrhi_out, 0);
    chk("rs_err",  bus.err_out, 128'(lit_err));
    step(1, 2'b11, 16'h6666, 0);
    step(0, 2'b00, 16'h0, 1);

    // 13-flit overflow stream
    do_reset();
    step(1, 2'b01, 16'hC000, 0);
    for (int k = 1; k <= 11; k++) step(1, 2'b10, 16'hC000 + 16'(k), 0);
    step(1, 2'b11, 16'hC00C, 0);
    chk("ov_cnt",   bus.flit_cnt_out, 11);
    chk("ov_state", bus.fsm_state_out, 2);
    chk("ov_dlo",   bus.data_out[15:0], 16'hC00A);
    chk("ov_err",   bus.err_out, 128'(lit_err));
    step(0, 2'b00, 16'h0, 1);

    // reset in the middle of a message
    do_reset();
    step(1, 2'b01, 16'hAAAA, 0);
    step(1, 2'b10, 16'hBBBB, 0);
    do_reset();
    chk("mr_ahi", bus.addrhi_out, 0);
    step(1, 2'b01, 16'h1357, 0);
    step(1, 2'b11, 16'h2468, 0);
    chk("mr_cnt",  bus.flit_cnt_out, 2);
    chk("mr_head", bus.head_flit_out, 16'h1357);
    chk("mr_ahi2", bus.addrhi_out, 16'h2468);
    chk("mr_vmsg", bus.v_msg_out, 1);
    step(0, 2'b00, 16'h0, 1);

    // random traffic
    for (int it = 0; it < 4000; it++) begin
      int r;
      int cr;
      logic [1:0] c;
      r  = int'($urandom_range(0, 299));
      cr = int'($urandom_range(0, 99));
      if (cr < 8)       c = 2'b00;
      else if (cr < 20) c = 2'b01;
      else if (cr < 88) c = 2'b10;
      else              c = 2'b11;
      if (r == 0)
        do_reset();
      else
        step($urandom_range(0, 3) != 0, c, 16'($urandom),
             $urandom_range(0, 3) == 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/download_fsm_datapath.md
# download_fsm_datapath

Receive side of the communication assist: reassembles the 16-bit flit stream arriving from the ring (head, address hi/lo, up to eight data flits) into a parallel message register set and hands it to the local cache/memory controller through a valid/ack handshake. It is the counterpart of the upload flit serializer and uses the same flit/ctrl encoding. A FSM controls a register datapath; one message is held at a time.

## Interface
Parameters:
- MAX_FLITS, 11, maximum flits per message (head + addrhi + addrlo + 8 data)
- FLIT_W, 16, flit width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- v_flit_in  in  1  flit_in/ctrl_in valid
- flit_in  in  16  flit payload
- ctrl_in  in  2  00 single-flit msg (head+tail), 01 head, 10 body, 11 tail
- flit_rdy_out  out  1  block can accept a flit this cycle
- v_msg_out  out  1  assembled message valid
- msg_ack_in  in  1  consumer takes message
- head_flit_out  out  16  flit 0
- addrhi_out  out  16  flit 1
- addrlo_out  out  16  flit 2
- data_out  out  128  flits 3..10, flit 3 in [127:112]
- flit_cnt_out  out  4  flits in held message (1..11)
- fsm_state_out  out  2  current state
- err_out  out  1  sticky protocol error

## Operation
- States: IDLE=00, BUSY=01, RDY=10; 11 unused, decodes to IDLE.
- Flit accepted when v_flit_in && flit_rdy_out; flit_rdy_out = (state != RDY), combinational.
- IDLE: ctrl 01 -> store flit 0, clear flits 1..10 to 0, cnt=1, -> BUSY. ctrl 00 -> same store/clear, cnt=1, -> RDY. ctrl 10/11 -> dropped, stay IDLE.
- BUSY: ctrl 10 -> store at slot cnt, cnt+1. ctrl 11 -> store at slot cnt, cnt+1, -> RDY. ctrl 01/00 -> restart: discard partial message, treat as new head per IDLE rules.
- Overflow: flit accepted in BUSY with cnt==MAX_FLITS is dropped; cnt saturates at 11; tail still moves to RDY.
- RDY: v_msg_out=1, outputs stable; msg_ack_in -> IDLE next cycle. Registers keep contents until next head.
- cnt is 4-bit, slot index = cnt, never wraps.

## Timing
- Reset: state IDLE, all storage and cnt 0, v_msg_out 0, err_out 0, flit_rdy_out 1.
- Tail (or ctrl 00) accepted at edge N -> v_msg_out high after edge N, same cycle flit_rdy_out low.
- msg_ack_in sampled at edge M in RDY -> IDLE after M; next head accepted at edge M+1 earliest.
- msg_ack_in outside RDY ignored.
- Reset asserted mid-message or in RDY: immediate return to reset values; partial message lost.
- Back-to-back flits every cycle supported in IDLE/BUSY.

## Configuration
- DOWNLOAD_ERR_CHK_EN defined: err_out sets (sticky until rst) on body/tail in IDLE, head/00 in BUSY (restart), or overflow drop.
- Undefined: same data-path behaviour, no detection logic; err_out tied 0.

## Structure
- Package download_pkg: state encodings, ctrl encodings (CTRL_SINGLE/HEAD/BODY/TAIL), MAX_FLITS, FLIT_W.
- Sub-module download_datapath: 11x16 flit registers, cnt register with clear/inc/saturate, slot decode, eq_max flag; FSM and error logic in top.

## Test plan
- Reset then 3-flit msg (01 0x1234, 10 0xA0A0, 11 0x0B0B) -> v_msg_out next cycle, head 0x1234, addrhi 0xA0A0, addrlo 0x0B0B, data 0, cnt 3.
- 11-flit msg with data 0xD001..0xD008 -> data_out[127:112]=0xD001, [15:0]=0xD008, cnt 11; hold ack 5 cycles -> outputs stable, flit_rdy_out 0, extra flits ignored.
- Single flit ctrl 00 value 0x00FF -> RDY with cnt 1; ack -> IDLE; next head accepted one cycle after ack edge.
- Head, body, then new head 0x5555 -> restart, cnt 1, head 0x5555; err_out 1 only with DOWNLOAD_ERR_CHK_EN.
- 13-flit stream (head, 11 body, tail) -> cnt 11, slots hold first 11 flits, err_out 1 with macro, 0 without.
- rst pulse mid-BUSY (after 2 flits) -> IDLE, cnt 0, all outputs 0, following message assembles correctly.
